spi_req_arbiter: RTL and testbench
==================================

SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface -- parameters
REQ-001 The block SHALL have parameter NREQ, default 3, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 20, giving the maximum number of sclk cycles per transaction from the spi_newdata assertion until spi_cs returns high.

Interface -- ports
REQ-003 The block SHALL have port sclk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, NREQ bits: per-requester transfer request, level.
REQ-006 The block SHALL have port req_data, input, 12*NREQ bits: 12-bit word of requester i at bits [12i+11:12i].
REQ-007 The block SHALL have port gnt, output, NREQ bits: one-hot, 1-cycle pulse when requester i's word is captured.
REQ-008 The block SHALL have port done, output, NREQ bits: one-hot, 1-cycle pulse when requester i's transfer completes.
REQ-009 The block SHALL have port err, output, 1 bit: 1-cycle pulse on transaction timeout.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port spi_newdata, output, 1 bit: start strobe to the SPI master.
REQ-012 The block SHALL have port spi_datain, output, 12 bits: word to the SPI master.
REQ-013 The block SHALL have port spi_cs, input, 1 bit: chip select from the SPI master, active low.

Function
REQ-014 The block SHALL implement states IDLE, START, BUSY and FINISH, with all outputs registered.
REQ-015 In IDLE, with any req bit high, the block SHALL select the winner round-robin, searching from (last_winner+1) mod NREQ upward with wrap.
REQ-016 The block SHALL capture the winner's req_data into spi_datain, pulse gnt[winner] and set spi_newdata, all on the next cycle, and move to START.
REQ-017 req and req_data SHALL be sampled only in IDLE; requests arriving in other states SHALL wait and SHALL NOT be lost while held.
REQ-018 A requester SHALL deassert req within one cycle after its gnt pulse; a req still high when the block returns to IDLE SHALL be treated as a new request.
REQ-019 In START, spi_newdata SHALL stay high until spi_cs is sampled low, then drop on the next edge while the state moves to BUSY.
REQ-020 In BUSY, spi_cs sampled high SHALL move the state to FINISH.
REQ-021 FINISH SHALL last 1 cycle: done[winner] pulses, last_winner is updated, the state returns to IDLE, and a new grant is possible on the following cycle.
REQ-022 spi_datain SHALL hold the granted word stable from the gnt cycle through FINISH.
REQ-023 A cycle counter SHALL clear on grant and increment in START and BUSY.
REQ-024 When the cycle counter reaches TIMEOUT, the block SHALL pulse err, drop spi_newdata, omit done, update last_winner, and return to IDLE.
REQ-025 Nominal latency for a 12-bit master SHALL be: gnt at cycle G; spi_cs low at about G+1; done within G+16 with TIMEOUT 20.
REQ-026 At most one gnt bit and at most one done bit SHALL be high in any cycle.
REQ-027 gnt and done SHALL never be high in the same cycle.
REQ-028 With req all zero, the block SHALL remain in IDLE with all pulse outputs low.

Reset
REQ-029 With reset high at a rising edge, the next state SHALL be IDLE.
REQ-030 With reset high at a rising edge, gnt, done, err, busy and spi_newdata SHALL be 0, spi_datain SHALL be 12'h000, the cycle counter SHALL be 0, and last_winner SHALL be NREQ-1 so that requester 0 has first priority.
REQ-031 Reset SHALL take priority over every transition, including mid-transfer; the interrupted transfer SHALL get neither done nor err.

Verification
REQ-032 Single request: req=3'b010 with data1=12'hA5C -> gnt=3'b010 one cycle later, spi_newdata high, spi_datain=12'hA5C; once spi_cs rises, done=3'b010 for 1 cycle.
REQ-033 Simultaneous requests: req=3'b111 held after reset -> grant order 0,1,2,0; each done precedes the next gnt.
REQ-034 Request during BUSY: req[2] rises while requester 0 transfers -> gnt[2] no earlier than the cycle after done[0]; busy stays low only in the IDLE cycle.
REQ-035 Timeout: spi_cs held high (master absent), single req[0] -> err pulse exactly TIMEOUT cycles after gnt, no done, busy low the next cycle, next grant goes to requester 1 if requesting.
REQ-036 Reset mid-transfer: reset asserted in BUSY -> next cycle all outputs at reset values; no done or err; a subsequent req[1] is granted before req[2] when both are high.

Source files
------------

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that hands 12-bit words from NREQ requesters to a single SPI master,
// tracking each transfer through spi_cs and aborting it after TIMEOUT cycles.
module spi_req_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 20
) (
    input  logic                 sclk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [12*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic                 busy,
    output logic                 spi_newdata,
    output logic [11:0]          spi_datain,
    input  logic                 spi_cs
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_BUSY   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   win_q, win_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [11:0]     data_q, data_d;
    logic            newdata_q, newdata_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    logic            pick_found_s;
    logic [IW-1:0]   pick_idx_s;
    logic [IW-1:0]   cand_s;
    logic            hit_s;
    logic [11:0]     pick_word_s;
    logic [CW-1:0]   cnt_inc_s;
    logic            timeout_s;

    // Round-robin search starting just after the last winner, first requester found wins
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = last_q;
        cand_s       = '0;
        hit_s        = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s       = IW'((int'(last_q) + k) % NREQ);
            hit_s        = req[cand_s] & ~pick_found_s;
            pick_idx_s   = hit_s ? cand_s : pick_idx_s;
            pick_found_s = pick_found_s | hit_s;
        end
    end

    assign pick_word_s = req_data[12*int'(pick_idx_s) +: 12];
    assign cnt_inc_s   = cnt_q + CNT_ONE;
    assign timeout_s   = (cnt_inc_s == CNT_LIMIT);

    // Transaction sequencing; the timeout check outranks every spi_cs transition
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        newdata_d = newdata_q;
        gnt_d     = '0;
        done_d    = '0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_found_s) begin
                    state_d   = S_START;
                    win_d     = pick_idx_s;
                    data_d    = pick_word_s;
                    gnt_d     = onehot(pick_idx_s);
                    newdata_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_START: begin
                cnt_d = cnt_inc_s;
                if (timeout_s) begin
                    state_d   = S_IDLE;
                    err_d     = 1'b1;
                    newdata_d = 1'b0;
                    last_d    = win_q;
                end else if (!spi_cs) begin
                    state_d   = S_BUSY;
                    newdata_d = 1'b0;
                end else begin
                    state_d   = S_START;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_inc_s;
                if (timeout_s) begin
                    state_d   = S_IDLE;
                    err_d     = 1'b1;
                    newdata_d = 1'b0;
                    last_d    = win_q;
                end else if (spi_cs) begin
                    state_d = S_FINISH;
                    done_d  = onehot(win_q);
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                last_d  = win_q;
            end
            default: begin
                state_d   = S_IDLE;
                newdata_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            last_q    <= LAST_RST;
            win_q     <= '0;
            cnt_q     <= '0;
            data_q    <= 12'h000;
            newdata_q <= 1'b0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            newdata_q <= newdata_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign spi_newdata = newdata_q;
    assign spi_datain  = data_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: a transaction-timeline reference model predicts every output
// each cycle while directed scenarios and random requests/master timings drive the block.
module tb_spi_req_arbiter;
    localparam int NREQ = 3;
    localparam int TO   = 20;

    logic            sclk = 1'b0;
    logic            reset;
    logic [2:0]      req;
    logic [35:0]     req_data;
    logic [2:0]      gnt;
    logic [2:0]      done;
    logic            err;
    logic            busy;
    logic            spi_newdata;
    logic [11:0]     spi_datain;
    logic            spi_cs;

    spi_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .sclk        (sclk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .spi_newdata (spi_newdata),
        .spi_datain  (spi_datain),
        .spi_cs      (spi_cs)
    );

    always #5 sclk = ~sclk;

    int          cyc;
    int          checks;
    int          errors;
    bit          act;
    bit          t_err;
    bit          rst_g;
    int          t_g;
    int          t_end;
    int          t_d;
    int          t_l;
    int          win;
    int          last_m;
    int          mode_g;
    logic [11:0] word_m;
    logic [2:0]  pend;
    logic [11:0] pdata [3];

    function automatic int rr(input int last, input logic [2:0] m);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    // One clock: compare all outputs against the timeline, then update requesters, model and drive
    task automatic step();
        logic [2:0] e_gnt;
        logic [2:0] e_done;
        logic       e_err;
        logic       e_busy;
        logic       e_nd;
        bit         idle_m;
        int         total;
        @(posedge sclk);
        #1;
        cyc++;
        e_gnt  = (act && cyc == t_g) ? (3'b001 << win) : 3'b000;
        e_done = (act && cyc == t_end && !t_err) ? (3'b001 << win) : 3'b000;
        e_err  = act && cyc == t_end && t_err;
        e_busy = act && cyc >= t_g && (cyc < t_end || (cyc == t_end && !t_err));
        e_nd   = act && cyc >= t_g && cyc < t_end && (t_d < 0 || cyc <= t_g + t_d);
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(e_err));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("spi_newdata", 32'(spi_newdata), 32'(e_nd));
        chk("spi_datain", 32'(spi_datain), 32'(word_m));

        if (act && cyc == t_g) pend[win] = 1'b0;
        idle_m = !act || (t_err ? (cyc >= t_end) : (cyc >= t_end + 1));
        if (rst_g) begin
            act    = 1'b0;
            word_m = 12'h000;
            last_m = NREQ - 1;
        end else if (idle_m && pend != 3'b000) begin
            win    = rr(last_m, pend);
            last_m = win;
            word_m = pdata[win];
            t_g    = cyc + 1;
            act    = 1'b1;
            if (mode_g == 1) begin
                t_d = -1;
                t_l = 0;
                total = TO;
            end else begin
                t_d = $urandom_range(0, 3);
                if (mode_g == 2) t_l = TO - 2 - t_d;
                else if (mode_g == 3) t_l = TO - 1 - t_d;
                else t_l = $urandom_range(1, 12);
                total = t_d + t_l + 1;
            end
            t_err = (total >= TO);
            t_end = t_err ? (t_g + TO) : (t_g + total);
        end

        reset    = rst_g;
        req      = pend;
        req_data = {pdata[2], pdata[1], pdata[0]};
        spi_cs   = !(act && t_d >= 0 && cyc >= t_g + t_d && cyc < t_g + t_d + t_l);
    endtask

    initial begin
        bit re0;
        int r;
        int k;
        cyc    = 0;
        checks = 0;
        errors = 0;
        act    = 1'b0;
        t_err  = 1'b0;
        t_g    = 0;
        t_end  = 0;
        t_d    = -1;
        t_l    = 0;
        win    = 0;
        last_m = NREQ - 1;
        mode_g = 0;
        word_m = 12'h000;
        pend   = 3'b000;
        for (int i = 0; i < 3; i++) pdata[i] = 12'h000;
        rst_g    = 1'b1;
        reset    = 1'b1;
        req      = 3'b000;
        req_data = 36'h0;
        spi_cs   = 1'b1;

        // Reset values and quiet idle
        step();
        step();
        rst_g = 1'b0;
        step();
        step();

        // Single request from requester 1 with a known word
        pdata[1] = 12'hA5C;
        pend[1]  = 1'b1;
        repeat (25) step();

        // All three requesting: order 0,1,2 then 0 again after it re-requests
        for (int i = 0; i < 3; i++) pdata[i] = 12'($urandom);
        pend = 3'b111;
        re0  = 1'b0;
        for (int i = 0; i < 90; i++) begin
            step();
            if (act && cyc == t_g && win == 0 && !re0) begin
                pend[0] = 1'b1;
                re0     = 1'b1;
            end
        end

        // Requester 2 arrives while requester 0 is mid-transfer
        pdata[0] = 12'($urandom);
        pend[0]  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (act && win == 0 && cyc == t_g + t_d + 1) break;
        end
        pdata[2] = 12'($urandom);
        pend[2]  = 1'b1;
        repeat (45) step();

        // Absent master: timeout on requester 0, requester 1 waiting
        mode_g  = 1;
        pend[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (act && cyc == t_g) break;
        end
        mode_g  = 0;
        pend[1] = 1'b1;
        repeat (45) step();

        // Transfer ending one cycle before the limit, then one hitting it exactly
        mode_g  = 2;
        pend[2] = 1'b1;
        repeat (25) step();
        mode_g  = 3;
        pend[1] = 1'b1;
        repeat (25) step();
        mode_g  = 0;

        // Reset while requester 0 is in BUSY, then 1 and 2 compete
        pend[0] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (act && win == 0 && cyc == t_g + t_d) break;
        end
        rst_g = 1'b1;
        step();
        rst_g   = 1'b0;
        pend[1] = 1'b1;
        pend[2] = 1'b1;
        repeat (45) step();

        // Random requests, master timings, timeouts and occasional resets
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 7);
            mode_g = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 2);
                if (!pend[k]) begin
                    pend[k]  = 1'b1;
                    pdata[k] = 12'($urandom);
                end
            end
            rst_g = ($urandom_range(0, 299) == 0);
            step();
        end
        rst_g = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
